dense_weight_updater: RTL

Writer side of the dense-layer weight memory: the counterpart of the dense forward pass, which only reads weights through a `raddr`/`rdata` port. After the backward pass has filled the gradient buffer, this block sweeps every weight word once. For each word it reads the weight and its gradient at the same address, applies an SGD step `w <- w - (g >>> LR_SHIFT)` lane by lane, and writes the result back through `waddr`/`wdata`/`we`. It sits between the training controller (`run`/`valid`) and the dual-port weight RAM.

---
 rtl/dense_weight_updater.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/dense_weight_updater.sv
// dense_weight_updater: sweeps the dense weight RAM once and writes back w - (g >>> LR_SHIFT) per lane.
// Define DENSE_UPDATE_SAT_EN to clamp each lane result instead of wrapping.
`ifndef N_LEN
`define N_LEN 16
`endif
`ifndef HID_DIM
`define HID_DIM 64
`endif
`ifndef CHAR_NUM
`define CHAR_NUM 16
`endif

module dense_weight_updater #(
   parameter int ADDR_WIDTH   = 10,
   parameter int DENSE_DATA_N = 8,
   parameter int DEPTH        = `HID_DIM * `CHAR_NUM / DENSE_DATA_N,
   parameter int LR_SHIFT     = 4
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            run,
   output logic                            valid,
   output logic [ADDR_WIDTH-1:0]           raddr,
   input  logic [DENSE_DATA_N*`N_LEN-1:0]  rdata,
   input  logic [DENSE_DATA_N*`N_LEN-1:0]  gdata,
   output logic                            we,
   output logic [ADDR_WIDTH-1:0]           waddr,
   output logic [DENSE_DATA_N*`N_LEN-1:0]  wdata
);

   localparam int LW = `N_LEN;
   localparam int WW = DENSE_DATA_N * LW;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

`ifdef DENSE_UPDATE_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                state_r;
   logic                  rd_pending_r;
   logic [ADDR_WIDTH-1:0] raddr_d_r;
   logic [WW-1:0]         upd_word_s;

   // One lane of the SGD step; the difference carries a guard bit so overflow is visible.
   function automatic logic [LW-1:0] sgd_lane(input logic [LW-1:0] w, input logic [LW-1:0] g);
      logic signed [LW-1:0] step;
      logic [LW:0]          diff;
      logic [LW-1:0]        res;
      step = $signed(g) >>> LR_SHIFT;
      diff = {w[LW-1], w} - {step[LW-1], step};
      if (SAT_EN && (diff[LW] != diff[LW-1])) begin
         res = diff[LW] ? {1'b1, {(LW-1){1'b0}}} : {1'b0, {(LW-1){1'b1}}};
      end else begin
         res = diff[LW-1:0];
      end
      return res;
   endfunction

   // Lane-parallel update of the word returned by the RAM this cycle
   always_comb begin
      upd_word_s = {WW{1'b0}};
      for (int j = 0; j < DENSE_DATA_N; j++) begin
         upd_word_s[j*LW +: LW] = sgd_lane(rdata[j*LW +: LW], gdata[j*LW +: LW]);
      end
   end

   // Sweep FSM, read tracking and registered write stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         raddr        <= {ADDR_WIDTH{1'b0}};
         raddr_d_r    <= {ADDR_WIDTH{1'b0}};
         rd_pending_r <= 1'b0;
         we           <= 1'b0;
         waddr        <= {ADDR_WIDTH{1'b0}};
         wdata        <= {WW{1'b0}};
         valid        <= 1'b0;
      end else begin
         // Gating with run drops the in-flight read on abort.
         we        <= rd_pending_r & run;
         waddr     <= raddr_d_r;
         wdata     <= upd_word_s;
         raddr_d_r <= raddr;
         if (!run) begin
            state_r      <= IDLE;
            raddr        <= {ADDR_WIDTH{1'b0}};
            rd_pending_r <= 1'b0;
            valid        <= 1'b0;
         end else begin
            case (state_r)
               IDLE: begin
                  rd_pending_r <= 1'b1;
                  valid        <= 1'b0;
                  if (raddr == LAST_ADDR) begin
                     state_r <= DRAIN;
                  end else begin
                     raddr   <= raddr + 1'b1;
                     state_r <= READ;
                  end
               end
               READ: begin
                  rd_pending_r <= 1'b1;
                  valid        <= 1'b0;
                  if (raddr == LAST_ADDR) begin
                     state_r <= DRAIN;
                  end else begin
                     raddr <= raddr + 1'b1;
                  end
               end
               DRAIN: begin
                  rd_pending_r <= 1'b0;
                  if (we && (waddr == LAST_ADDR)) begin
                     state_r <= DONE;
                     valid   <= 1'b1;
                  end else begin
                     valid <= 1'b0;
                  end
               end
               DONE: begin
                  rd_pending_r <= 1'b0;
                  valid        <= 1'b1;
               end
               default: begin
                  state_r      <= IDLE;
                  rd_pending_r <= 1'b0;
                  valid        <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
